// File: rtl/vote_capture_if.sv
// Judge-button / vote bundle between the voting front end and its environment.
// The master drives start and the raw buttons; the slave returns latched votes and status.
interface vote_capture_if;
    logic       start;
    logic       btn_a;
    logic       btn_b;
    logic       btn_c;
    logic       vote_a;
    logic       vote_b;
    logic       vote_c;
    logic [1:0] yes_count;
    logic       busy;
    logic       votes_valid;

    modport master (
        output start, btn_a, btn_b, btn_c,
        input  vote_a, vote_b, vote_c, yes_count, busy, votes_valid
    );

    modport slave (
        input  start, btn_a, btn_b, btn_c,
        output vote_a, vote_b, vote_c, yes_count, busy, votes_valid
    );
endinterface

// File: rtl/vote_capture.sv
// Three-judge vote capture: synchronise and debounce the buttons, collect sticky votes
// during a timed window, then present them stable with a one-cycle valid strobe.
module vote_capture #(
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned WINDOW_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    vote_capture_if.slave  vc_if
);

    localparam int unsigned NCH   = 3;
    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [NCH-1:0]     w_btn;
    logic [NCH-1:0]     r_sync1;
    logic [NCH-1:0]     r_sync2;
    logic [NCH-1:0]     r_deb;
    logic [DEB_W-1:0]   r_deb_cnt [NCH];

    logic [WIN_W-1:0]   r_win_cnt;
    logic [WIN_W-1:0]   w_win_nxt;
    logic [NCH-1:0]     r_vote;
    logic [NCH-1:0]     w_vote_nxt;
    logic [1:0]         r_yes;
    logic [1:0]         w_yes_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_valid;
    logic               w_valid_nxt;

    assign w_btn = {vc_if.btn_c, vc_if.btn_b, vc_if.btn_a};

    // Two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: flip once the synchronised level has disagreed for DEB_CYCLES cycles in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: window closes on its last cycle or as soon as every judge has voted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (vc_if.start) begin
                    w_state_nxt = S_OPEN;
                end
            end
            S_OPEN: begin
                if ((r_win_cnt == WIN_W'(1)) || (&r_vote)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs and datapath next values; votes are level-sampled and sticky while open.
    always_comb begin
        w_vote_nxt  = r_vote;
        w_win_nxt   = r_win_cnt;
        w_busy_nxt  = (w_state_nxt == S_OPEN);
        w_valid_nxt = (w_state_nxt == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (vc_if.start) begin
                    w_vote_nxt = '0;
                    w_win_nxt  = WIN_W'(WINDOW_CYCLES);
                end
            end
            S_OPEN: begin
                w_vote_nxt = r_vote | r_deb;
                w_win_nxt  = r_win_cnt - WIN_W'(1);
            end
            default: begin
            end
        endcase
        w_yes_nxt = 2'(w_vote_nxt[0]) + 2'(w_vote_nxt[1]) + 2'(w_vote_nxt[2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt <= '0;
            r_vote    <= '0;
            r_yes     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_win_cnt <= w_win_nxt;
            r_vote    <= w_vote_nxt;
            r_yes     <= w_yes_nxt;
            r_busy    <= w_busy_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    assign vc_if.vote_a      = r_vote[0];
    assign vc_if.vote_b      = r_vote[1];
    assign vc_if.vote_c      = r_vote[2];
    assign vc_if.yes_count   = r_yes;
    assign vc_if.busy        = r_busy;
    assign vc_if.votes_valid = r_valid;

endmodule

// File: tb/tb_vote_capture.sv
// Bench for vote_capture: directed scenarios with literal expectations plus a long
// randomized run compared every cycle against a behavioural vote-window model.
module tb_vote_capture;

    localparam int unsigned DEB = 4;
    localparam int unsigned WIN = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    vote_capture_if vif ();

    vote_capture #(.DEB_CYCLES(DEB), .WINDOW_CYCLES(WIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vc_if (vif)
    );

    always #5 clk = ~clk;

    // Behavioural model: register values of the current cycle.
    bit        m_busy, m_valid;
    bit [2:0]  m_vote, m_deb;
    int        m_age;
    bit [15:0] m_hist [3];   // bit0 = raw button sampled at previous edge

    // True when the raw samples that reached the synchroniser output in the last DEB cycles all equal v.
    function automatic bit settled(input bit [15:0] h, input bit v);
        for (int i = 1; i <= int'(DEB); i++) begin
            if (h[i] != v) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_vote = 0; m_deb = 0; m_age = 0;
            for (int c = 0; c < 3; c++) m_hist[c] = '0;
        end else begin
            bit [2:0] raw;
            bit [2:0] deb_n;
            bit [2:0] v_cur;
            raw = {vif.btn_c, vif.btn_b, vif.btn_a};
            for (int c = 0; c < 3; c++) begin
                deb_n[c]  = settled(m_hist[c], !m_deb[c]) ? !m_deb[c] : m_deb[c];
                m_hist[c] = {m_hist[c][14:0], raw[c]};
            end
            if (m_valid) begin
                m_valid = 0;
            end else if (m_busy) begin
                v_cur  = m_vote;
                m_vote = m_vote | m_deb;
                if (m_age == int'(WIN) || v_cur == 3'b111) begin
                    m_busy  = 0;
                    m_valid = 1;
                end else begin
                    m_age++;
                end
            end else if (vif.start) begin
                m_busy = 1;
                m_age  = 1;
                m_vote = 0;
            end
            m_deb = deb_n;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // {vote_c, vote_b, vote_a, yes_count[1:0], busy, votes_valid}
    function automatic logic [6:0] outs();
        return {vif.vote_c, vif.vote_b, vif.vote_a, vif.yes_count, vif.busy, vif.votes_valid};
    endfunction

    always @(negedge clk) begin
        check("model", 32'(outs()),
              32'({m_vote[2], m_vote[1], m_vote[0], 2'($countones(m_vote)), m_busy, m_valid}));
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_btn(input bit a, input bit b, input bit c);
        vif.btn_a = a; vif.btn_b = b; vif.btn_c = c;
    endtask

    task automatic settle();
        vif.start = 0;
        set_btn(0, 0, 0);
        repeat (12) tick();
    endtask

    task automatic check_lit(input int sc, input int n);
        case (sc)
            0: begin
                if (n == 0)  check("reset_state", 32'(outs()), 32'(7'b000_00_0_0));
                if (n == 1)  check("2y_busy_c1", 32'(vif.busy), 32'd1);
                if (n == 16) check("2y_c16", 32'(outs()), 32'(7'b011_10_1_0));
                if (n == 17) check("2y_done", 32'(outs()), 32'(7'b011_10_0_1));
                if (n == 18) check("2y_hold", 32'(outs()), 32'(7'b011_10_0_0));
            end
            1: begin
                if (n == 7)  check("ec_c7", 32'(outs()), 32'(7'b000_00_1_0));
                if (n == 8)  check("ec_c8", 32'(outs()), 32'(7'b111_11_1_0));
                if (n == 9)  check("ec_done", 32'(outs()), 32'(7'b111_11_0_1));
                if (n == 10) check("ec_hold", 32'(outs()), 32'(7'b111_11_0_0));
            end
            2: begin
                if (n == 8)  check("gl_c8", 32'(outs()), 32'(7'b001_01_1_0));
                if (n == 17) check("gl_done", 32'(outs()), 32'(7'b001_01_0_1));
            end
            3: begin
                if (n == 16) check("is_c16", 32'(outs()), 32'(7'b010_01_1_0));
                if (n == 17) check("is_done", 32'(outs()), 32'(7'b010_01_0_1));
                if (n == 18) check("is_hold", 32'(outs()), 32'(7'b010_01_0_0));
            end
            default: begin
            end
        endcase
    endtask

    // Window opened by start sampled at edge 0; cycle n ends at edge n.
    task automatic run_dir(input int sc);
        vif.start = 1;
        check_lit(sc, 0);
        for (int n = 1; n <= 20; n++) begin
            tick();
            vif.start = (sc == 3 && n == 5);
            case (sc)
                0:       set_btn(n >= 2 && n <= 11, n >= 2 && n <= 11, 0);
                1:       set_btn(n >= 1, n >= 1, n >= 1);
                2:       set_btn(n >= 1, 0, n >= 2 && n <= 4);
                default: set_btn(0, n >= 1, 0);
            endcase
            check_lit(sc, n);
        end
        settle();
    endtask

    initial begin
        int       run [3];
        bit [2:0] lvl;
        vif.start = 0;
        set_btn(0, 0, 0);

        // Reset held with toggling buttons.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_btn(i[0], i[1], i[2]);
            vif.start = i[0];
            check("in_reset", 32'(outs()), 32'd0);
        end
        vif.start = 0;
        set_btn(0, 0, 0);
        rst_n = 1;
        repeat (6) begin
            tick();
            check("post_reset", 32'(outs()), 32'd0);
        end

        for (int sc = 0; sc < 4; sc++) run_dir(sc);

        // Mid-window reset, then a normal window after release.
        vif.start = 1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            vif.start = 0;
            set_btn(1, 0, 0);
        end
        check("mr_vote_a", 32'(vif.vote_a), 32'd1);
        #1 rst_n = 0;
        #1 check("mr_async", 32'(outs()), 32'd0);
        set_btn(0, 0, 0);
        tick();
        tick();
        rst_n = 1;
        tick();
        vif.start = 1;
        tick();
        vif.start = 0;
        check("mr_restart", 32'(outs()), 32'(7'b000_00_1_0));
        repeat (16) tick();
        check("mr_done", 32'(outs()), 32'(7'b000_00_0_1));
        settle();

        // Back-to-back: early close, then start in the cycle after DONE.
        vif.start = 1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            vif.start = (n == 10);
            set_btn(n < 9, n < 9, n < 9);
            if (n == 9)  check("bb_done1", 32'(outs()), 32'(7'b111_11_0_1));
            if (n == 11) check("bb_clear", 32'(outs()), 32'(7'b000_00_1_0));
            if (n == 13) check("bb_done2", 32'(outs()), 32'(7'b111_11_0_1));
        end
        settle();

        // Randomized run with level runs on each button, random starts and rare resets.
        run = '{0, 0, 0};
        lvl = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 3; c++) begin
                if (run[c] == 0) begin
                    lvl[c] = 1'($urandom_range(0, 1));
                    run[c] = int'($urandom_range(1, 9));
                end
                run[c]--;
            end
            set_btn(lvl[0], lvl[1], lvl[2]);
            vif.start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 0;
                tick();
                tick();
                rst_n = 1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vote_capture.md
# vote_capture

Front-end stage of the three-judge voting unit. Synchronises and debounces three raw judge push-buttons and collects each judge's vote during a timed voting window opened by `start`. It then presents the three latched votes, held stable, on `vote_a/b/c`, which feed the majority voter directly. A one-cycle `votes_valid` strobe marks the cycle at which the downstream majority output becomes meaningful.

## Interface
Parameters:
- `DEB_CYCLES`, default 4: consecutive cycles a synchronised button must differ from its debounced value before the debounced value changes; legal range ≥2.
- `WINDOW_CYCLES`, default 16: maximum length of the voting window in clock cycles; legal range ≥2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  system clock; all state updates on the rising edge.
  - `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  synchronous pulse that opens a voting window; ignored unless the block is idle.
- `btn_a`, `btn_b`, `btn_c`  in  1 each  raw asynchronous judge buttons, active-high.
- `vote_a`, `vote_b`, `vote_c`  out  1 each  latched votes; these drive majority-voter inputs a, b and c.
- `yes_count`  out  2  number of latched votes equal to 1 (0..3).
- `busy`  out  1  high while a window is open.
- `votes_valid`  out  1  one-cycle strobe; votes are final.

## Operation
- Each button passes through a two-flop synchroniser and then a per-channel debouncer.
- Debouncer behaviour per channel:
  - The counter increments while the synchronised value differs from the debounced value `deb_x`.
  - The counter clears whenever the two agree.
  - When the counter reaches `DEB_CYCLES`, `deb_x` takes the synchronised value and the counter clears.
- FSM states and transitions:
  - IDLE: `start` → OPEN. On that same edge, clear all votes and load the window counter with `WINDOW_CYCLES`.
  - OPEN: in every OPEN cycle, `deb_x`=1 sets `vote_x` at the next edge.
    - Votes are sticky for the rest of the window.
    - The test is level-based, so a button already held down before the window opens counts once debounced.
  - OPEN → DONE when either condition holds:
    - the window counter reaches 1 (decremented each OPEN cycle), or
    - all three vote registers read 1 (early close).
  - DONE: `votes_valid`=1 for exactly this cycle; the next state is always IDLE.
- Votes hold their values from DONE onward through IDLE until the next accepted `start` clears them.
- `yes_count` is the registered sum of the vote registers and is always consistent with `vote_a/b/c` in the same cycle.
- `start` is ignored in OPEN and in DONE, with no effect on any state.
- The debouncers run continuously in every state.
- Reset at any time, including mid-window: FSM returns to IDLE, and all counters, synchronisers, debounced values and votes are cleared.

## Timing
- Reset values: `vote_a/b/c`=0, `yes_count`=0, `busy`=0, `votes_valid`=0.
- Button-to-debounced latency: 2 synchroniser cycles + `DEB_CYCLES` cycles.
- A debounced pulse shorter than `DEB_CYCLES` synchronised cycles never changes `deb_x`.
- Debounced-to-vote latency: 1 cycle.
- Let `start` be sampled at edge k:
  - `busy` is 1 in cycles k+1 .. k+`WINDOW_CYCLES`.
  - Without early close, DONE occupies cycle k+`WINDOW_CYCLES`+1 with `votes_valid`=1 and `busy`=0.
- A vote set at the last OPEN edge is included in the DONE-cycle outputs.
- Early close: the first OPEN cycle in which all three vote registers read 1 is followed by DONE in the next cycle.
- Back-to-back operation: `start` sampled in the cycle after DONE is accepted.
- Throughput: one window per `WINDOW_CYCLES`+2 cycles at most.

## Test plan
Defaults for all scenarios: `DEB_CYCLES`=4, `WINDOW_CYCLES`=16; `start` pulsed at edge 0.
- Reset: hold `rst_n`=0 with buttons toggling, then release → all outputs 0, `busy`=0, no `votes_valid` until a `start`.
- Two yes votes: `btn_a` and `btn_b` high from cycle 2 for 10 cycles, `btn_c` low → `busy` high in cycles 1..16. In cycle 17: `votes_valid`=1, votes a/b/c = 1/1/0, `yes_count`=2.
- Early close: all three buttons high from cycle 1 → all votes 1 by cycle 8. DONE with `votes_valid`=1 in cycle 9, `yes_count`=3, and `busy` falls early.
- Glitch rejection: `btn_c` high for 3 cycles only, `btn_a` held high → `vote_c`=0 at DONE (cycle 17), `yes_count`=1.
- Ignored start and mid-window reset: pulse `start` again at cycle 5 → window still ends at cycle 17. New run: assert `rst_n`=0 at cycle 8 with `vote_a`=1 → outputs immediately 0 and FSM in IDLE; after release, `start` is accepted normally.
- Back-to-back windows: `start` pulsed in the cycle after DONE → `busy`=1 in the next cycle, and votes clear to 0/0/0 before new votes latch.
